serial_link_axis_flit_tx: RTL and testbench
===========================================

Name: serial_link_axis_flit_tx

Overview:
- Transmit-side data-link framer for the serial link.
- Consumes the wide payload stream that the network layer emits, sliced into fixed-width flits, least-significant slice first, for the physical layer.
- Gates payload acceptance with credits returned by the remote receiver, so the far end's payload buffer can never overflow.
- Sits between the network-layer payload FIFO output and the PHY serializer.

Parameters:
- PayloadW, 128, payload width in bits (≥1).
- FlitW, 32, flit width in bits (≥1).
- NumCredits, 8, remote receive-buffer depth in payloads; reset credit count.
- NumFlits (derived, localparam), ceil(PayloadW/FlitW), data flits per payload.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- payload_valid_i  in  1  payload valid.
- payload_ready_o  out  1  payload accepted when valid&ready.
- payload_data_i  in  PayloadW  payload.
- flit_valid_o  out  1  flit valid.
- flit_ready_i  in  1  PHY accepts flit.
- flit_data_o  out  FlitW  flit data.
- flit_last_o  out  1  final flit of the current payload.
- credit_return_i  in  1  one-cycle pulse: remote freed one payload slot.
- credits_o  out  $clog2(NumCredits+1)  current credit count.
- credit_err_o  out  1  sticky flag: credit returned while count == NumCredits.

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values:
  - FSM Idle, flit index 0.
  - credits_o = NumCredits.
  - credit_err_o = 0, flit_valid_o = 0, flit_last_o = 0, flit_data_o = 0.
  - payload_ready_o = 1 (credits > 0 at reset).
- States:
  - Idle: flit_valid_o = 0. payload_ready_o = (credits > 0). On accept: latch payload into register, idx = 0, consume one credit, go to Send.
  - Send:
    - flit_valid_o = 1, flit_data_o = latched[idx*FlitW +: FlitW].
    - The final flit is zero-padded above PayloadW.
    - flit_last_o = (idx == NumFlits-1).
    - On handshake with !last: idx++.
    - On handshake with last: go to Idle, unless a new payload is accepted in the same cycle; then reload, idx = 0, stay in Send.
- Back-to-back: payload_ready_o = (Idle & credits > 0) | (Send & flit_valid_o & flit_ready_i & flit_last_o & credits > 0). There is no bubble between payloads.
- Handshake stability: while flit_valid_o = 1 and flit_ready_i = 0, flit_data_o and flit_last_o hold stable and flit_valid_o stays 1.
- Latency: payload accept at cycle N → first flit valid at N+1. Each payload occupies exactly NumFlits accepted flit cycles.
- Credit arithmetic:
  - Decrement on payload accept; increment on credit_return_i.
  - Both in the same cycle → count unchanged.
  - Return at count == NumCredits without a simultaneous consume → count saturates and credit_err_o sets. It clears only on reset.
  - Credits 0 → payload_ready_o = 0; a flit burst already in progress still completes.
- NumFlits == 1: every flit has flit_last_o = 1; the FSM stays in Send under back-to-back traffic.
- Reset mid-burst: the burst is abandoned, the partial payload is dropped, and credits return to NumCredits.
- payload_valid_i may drop without a handshake; no state changes in that case.

Optional Feature:
SERIAL_LINK_FLIT_CHECKSUM_EN:
- When defined: after the NumFlits data flits, one extra flit carries the XOR of all data flits of that payload.
  - The checksum accumulates per accepted data flit and resets on payload accept.
  - flit_last_o is asserted only on the checksum flit, which follows the same stall rules.
  - Back-to-back acceptance is tied to the checksum-flit handshake.
- When undefined: there is no checksum flit or accumulator register; the flit count is exactly NumFlits.

Test Plan:
- Single payload 0x0F0E0D0C_0B0A0908_07060504_03020100, flit_ready_i tied 1 → flits 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C on consecutive cycles; last on the 4th; credits_o 8 → 7.
- Back-to-back: 3 payloads held valid, ready = 1 → 12 contiguous flit cycles with no bubble; credits_o = 5.
- Stall: flit_ready_i = 0 for 5 cycles mid-burst at idx 2 → flit_data_o holds 0x0B0A0908 and flit_valid_o stays 1 throughout; order preserved afterwards.
- Credit exhaustion: NumCredits = 2, 3 payloads offered, no returns → third payload_ready_o = 0. One credit_return_i pulse → third payload accepted the next cycle.
- Credit edge cases:
  - Simultaneous consume and return → credits_o unchanged.
  - Return at credits = 8 → credits_o stays 8 and credit_err_o = 1 until rst_i.
- Reset mid-burst after flit 1 → next cycle flit_valid_o = 0, credits_o = 8. The next payload starts at idx 0.
- Checksum (macro defined): payload above → 5th flit = 0x00000000 (XOR of the four flits) with flit_last_o = 1.

Source files
------------

// File: rtl/serial_link_axis_flit_tx.sv
// Credit-gated framer: slices each payload into FlitW flits, LS slice first (SERIAL_LINK_FLIT_CHECKSUM_EN adds an XOR flit).
// Latency: payload accept at cycle N gives its first flit valid at N+1; no bubble between back-to-back payloads.
// Backpressure: flit_ready_i low holds the current flit stable; payload_ready_o drops when credits run out or a burst is mid-flight.
module serial_link_axis_flit_tx #(
  parameter int PayloadW   = 128,
  parameter int FlitW      = 32,
  parameter int NumCredits = 8
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              payload_valid_i,
  output logic                              payload_ready_o,
  input  logic [PayloadW-1:0]               payload_data_i,
  output logic                              flit_valid_o,
  input  logic                              flit_ready_i,
  output logic [FlitW-1:0]                  flit_data_o,
  output logic                              flit_last_o,
  input  logic                              credit_return_i,
  output logic [$clog2(NumCredits+1)-1:0]   credits_o,
  output logic                              credit_err_o
);

  localparam int NumFlits = (PayloadW + FlitW - 1) / FlitW;
`ifdef SERIAL_LINK_FLIT_CHECKSUM_EN
  localparam int TotalFlits = NumFlits + 1;
`else
  localparam int TotalFlits = NumFlits;
`endif
  localparam int IdxW  = (TotalFlits > 1) ? $clog2(TotalFlits) : 1;
  localparam int CredW = $clog2(NumCredits + 1);
  localparam int PadW  = NumFlits * FlitW;
  localparam logic [IdxW-1:0]  LastIdx = IdxW'(TotalFlits - 1);
  localparam logic [CredW-1:0] MaxCred = CredW'(NumCredits);

  typedef enum logic {Idle, Send} state_e;

  state_e          state_q;
  logic [IdxW-1:0] idx_q;
  logic [PadW-1:0] shift_q;
  logic [PadW-1:0] payload_pad;
  logic            credit_avail;
  logic            flit_hs;
  logic            accept;

`ifdef SERIAL_LINK_FLIT_CHECKSUM_EN
  localparam logic [IdxW-1:0] DataLastIdx = IdxW'(NumFlits - 1);
  logic [FlitW-1:0] csum_q;
`endif

  // Zero-extension pads the top flit when PayloadW is not a multiple of FlitW.
  assign payload_pad  = PadW'(payload_data_i);
  assign credit_avail = (credits_o != '0);
  assign flit_hs      = flit_valid_o & flit_ready_i;

  // Accepting on the last-flit handshake is what removes the inter-payload bubble.
  assign payload_ready_o = credit_avail &
                           ((state_q == Idle) | ((state_q == Send) & flit_hs & flit_last_o));
  assign accept = payload_valid_i & payload_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= Idle;
      idx_q        <= '0;
      shift_q      <= '0;
      flit_valid_o <= 1'b0;
      flit_last_o  <= 1'b0;
      flit_data_o  <= '0;
      credits_o    <= MaxCred;
      credit_err_o <= 1'b0;
`ifdef SERIAL_LINK_FLIT_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      // A return at full count with no consume means the far end lied; saturate and flag.
      if (credit_return_i && !accept) begin
        if (credits_o == MaxCred) credit_err_o <= 1'b1;
        else                      credits_o    <= credits_o + 1'b1;
      end else if (accept && !credit_return_i) begin
        credits_o <= credits_o - 1'b1;
      end

      if (accept) begin
        state_q      <= Send;
        idx_q        <= '0;
        flit_valid_o <= 1'b1;
        flit_last_o  <= (TotalFlits == 1);
        flit_data_o  <= payload_pad[FlitW-1:0];
        shift_q      <= payload_pad >> FlitW;
`ifdef SERIAL_LINK_FLIT_CHECKSUM_EN
        csum_q       <= '0;
`endif
      end else if (flit_hs) begin
        if (flit_last_o) begin
          state_q      <= Idle;
          flit_valid_o <= 1'b0;
          flit_last_o  <= 1'b0;
        end else begin
          idx_q       <= idx_q + 1'b1;
          flit_last_o <= ((idx_q + 1'b1) == LastIdx);
          shift_q     <= shift_q >> FlitW;
`ifdef SERIAL_LINK_FLIT_CHECKSUM_EN
          csum_q <= csum_q ^ flit_data_o;
          if (idx_q == DataLastIdx) flit_data_o <= csum_q ^ flit_data_o;
          else                      flit_data_o <= shift_q[FlitW-1:0];
`else
          flit_data_o <= shift_q[FlitW-1:0];
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_link_axis_flit_tx.sv
// Randomized and directed bench for serial_link_axis_flit_tx with a queue-based flit/credit model.
module tb_serial_link_axis_flit_tx;
  localparam int PW = 128;
  localparam int FW = 32;
  localparam int NC = 8;
  localparam int NF = 4;
  localparam int CW = 4;
`ifdef SERIAL_LINK_FLIT_CHECKSUM_EN
  localparam int TF = NF + 1;
`else
  localparam int TF = NF;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          payload_valid, payload_ready;
  logic [PW-1:0] payload_data;
  logic          flit_valid, flit_ready, flit_last;
  logic [FW-1:0] flit_data;
  logic          credit_return;
  logic [CW-1:0] credits;
  logic          credit_err;

  logic          v2, r2, fv2, fl2, cr2, e2;
  logic          fr2 = 1'b1;
  logic [PW-1:0] d2;
  logic [FW-1:0] fd2;
  logic [1:0]    c2;

  serial_link_axis_flit_tx #(.PayloadW(PW), .FlitW(FW), .NumCredits(NC)) dut (
    .clk_i(clk), .rst_i(rst),
    .payload_valid_i(payload_valid), .payload_ready_o(payload_ready), .payload_data_i(payload_data),
    .flit_valid_o(flit_valid), .flit_ready_i(flit_ready), .flit_data_o(flit_data), .flit_last_o(flit_last),
    .credit_return_i(credit_return), .credits_o(credits), .credit_err_o(credit_err)
  );

  serial_link_axis_flit_tx #(.PayloadW(PW), .FlitW(FW), .NumCredits(2)) dut2 (
    .clk_i(clk), .rst_i(rst),
    .payload_valid_i(v2), .payload_ready_o(r2), .payload_data_i(d2),
    .flit_valid_o(fv2), .flit_ready_i(fr2), .flit_data_o(fd2), .flit_last_o(fl2),
    .credit_return_i(cr2), .credits_o(c2), .credit_err_o(e2)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [FW-1:0] exp_d[$];
  bit            exp_l[$];
  logic [FW-1:0] log_d[$];
  bit            log_l[$];
  int            log_c[$];
  int            m_credits;
  bit            m_err;
  bit            prev_stall, prev_acc;
  logic [FW-1:0] prev_data;
  logic          prev_last;

  // Reference: a payload becomes NF flits, LS slice first, plus an XOR flit when enabled.
  function automatic void push_payload(input logic [PW-1:0] p);
    logic [FW-1:0] x;
    x = '0;
    for (int i = 0; i < NF; i++) begin
      exp_d.push_back(p[i*FW +: FW]);
      exp_l.push_back(TF == NF && i == NF - 1);
      x ^= p[i*FW +: FW];
    end
`ifdef SERIAL_LINK_FLIT_CHECKSUM_EN
    exp_d.push_back(x);
    exp_l.push_back(1'b1);
`endif
  endfunction

  function automatic void reset_model();
    m_credits = NC;
    m_err = 1'b0;
    exp_d.delete();
    exp_l.delete();
    prev_stall = 1'b0;
    prev_acc = 1'b0;
  endfunction

  function automatic void clear_log();
    log_d.delete();
    log_l.delete();
    log_c.delete();
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    payload_valid = 1'b0;
    flit_ready = 1'b0;
    credit_return = 1'b0;
    v2 = 1'b0;
    cr2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    reset_model();
  endtask

  // One clock of the main DUT: check state at negedge, update the model, advance.
  task automatic cycle(output bit acc);
    logic [FW-1:0] ed;
    bit el;
    @(negedge clk);
    checks++;
    if (credits !== CW'(m_credits)) begin
      errors++;
      $display("FAIL credits cyc %0d got %0d want %0d", cyc, credits, m_credits);
    end
    checks++;
    if (credit_err !== m_err) begin
      errors++;
      $display("FAIL credit_err cyc %0d got %b want %b", cyc, credit_err, m_err);
    end
    checks++;
    if (payload_ready === 1'b1 && m_credits == 0) begin
      errors++;
      $display("FAIL ready_no_credit cyc %0d got ready=1 want 0", cyc);
    end
    if (prev_stall) begin
      checks++;
      if (flit_valid !== 1'b1 || flit_data !== prev_data || flit_last !== prev_last) begin
        errors++;
        $display("FAIL stall_hold cyc %0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                 cyc, flit_valid, flit_data, flit_last, prev_data, prev_last);
      end
    end
    if (prev_acc) begin
      checks++;
      if (flit_valid !== 1'b1) begin
        errors++;
        $display("FAIL first_flit_latency cyc %0d got valid=%b want 1", cyc, flit_valid);
      end
    end
    if (flit_valid === 1'b1 && flit_ready) begin
      checks++;
      if (exp_d.size() == 0) begin
        errors++;
        $display("FAIL spurious_flit cyc %0d got %h want none", cyc, flit_data);
      end else begin
        ed = exp_d.pop_front();
        el = exp_l.pop_front();
        if (flit_data !== ed || flit_last !== el) begin
          errors++;
          $display("FAIL flit cyc %0d got %h last %b want %h last %b", cyc, flit_data, flit_last, ed, el);
        end
      end
      log_d.push_back(flit_data);
      log_l.push_back(flit_last);
      log_c.push_back(cyc);
    end
    acc = payload_valid && (payload_ready === 1'b1);
    if (acc) push_payload(payload_data);
    if (credit_return && !acc) begin
      if (m_credits == NC) m_err = 1'b1;
      else m_credits++;
    end else if (acc && !credit_return) begin
      m_credits--;
    end
    prev_stall = (flit_valid === 1'b1) && !flit_ready;
    prev_data = flit_data;
    prev_last = flit_last;
    prev_acc = acc;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    bit a;
    payload_valid = 1'b0;
    flit_ready = 1'b1;
    credit_return = 1'b0;
    for (int i = 0; i < 64 && exp_d.size() > 0; i++) cycle(a);
    checks++;
    if (exp_d.size() != 0 || flit_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain got %0d pending valid=%b want 0 pending valid=0", exp_d.size(), flit_valid);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (flit_valid !== 1'b0 || flit_last !== 1'b0 || flit_data !== '0 || credits !== 4'd8 ||
        credit_err !== 1'b0 || payload_ready !== 1'b1 || c2 !== 2'd2) begin
      errors++;
      $display("FAIL reset_state got v=%b l=%b d=%h c=%0d e=%b r=%b c2=%0d want 0 0 0 8 0 1 2",
               flit_valid, flit_last, flit_data, credits, credit_err, payload_ready, c2);
    end
  endtask

  task automatic test_single();
    bit a;
    logic [FW-1:0] want [5];
    want = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C, 32'h00000000};
    do_reset();
    clear_log();
    payload_data = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    payload_valid = 1'b1;
    flit_ready = 1'b1;
    cycle(a);
    checks++;
    if (!a) begin
      errors++;
      $display("FAIL single_accept got 0 want 1");
    end
    drain();
    checks++;
    if (log_d.size() != TF) begin
      errors++;
      $display("FAIL single_count got %0d want %0d", log_d.size(), TF);
    end else begin
      for (int i = 0; i < TF; i++) begin
        checks++;
        if (log_d[i] !== want[i] || log_l[i] !== (i == TF - 1) || log_c[i] != log_c[0] + i) begin
          errors++;
          $display("FAIL single_flit%0d got %h last %b cyc %0d want %h last %b cyc %0d",
                   i, log_d[i], log_l[i], log_c[i], want[i], (i == TF - 1), log_c[0] + i);
        end
      end
    end
    checks++;
    if (credits !== 4'd7) begin
      errors++;
      $display("FAIL single_credits got %0d want 7", credits);
    end
  endtask

  task automatic test_back_to_back();
    bit a;
    int k;
    logic [PW-1:0] pl [3];
    do_reset();
    clear_log();
    for (int i = 0; i < 3; i++) pl[i] = {$urandom, $urandom, $urandom, $urandom};
    flit_ready = 1'b1;
    k = 0;
    for (int i = 0; i < 40 && k < 3; i++) begin
      payload_valid = 1'b1;
      payload_data = pl[k];
      cycle(a);
      if (a) k++;
    end
    checks++;
    if (k != 3) begin
      errors++;
      $display("FAIL b2b_accepts got %0d want 3", k);
    end
    drain();
    checks++;
    if (log_d.size() != 3 * TF || log_c[log_c.size()-1] - log_c[0] != 3 * TF - 1) begin
      errors++;
      $display("FAIL b2b_contiguous got %0d flits span %0d want %0d span %0d",
               log_d.size(), log_c[log_c.size()-1] - log_c[0] + 1, 3 * TF, 3 * TF);
    end
    checks++;
    if (credits !== 4'd5) begin
      errors++;
      $display("FAIL b2b_credits got %0d want 5", credits);
    end
  endtask

  task automatic test_stall();
    bit a;
    do_reset();
    payload_data = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    payload_valid = 1'b1;
    flit_ready = 1'b1;
    cycle(a);
    payload_valid = 1'b0;
    cycle(a);
    cycle(a);
    flit_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle(a);
      checks++;
      if (flit_valid !== 1'b1 || flit_data !== 32'h0B0A0908) begin
        errors++;
        $display("FAIL stall%0d got v=%b d=%h want v=1 d=0b0a0908", i, flit_valid, flit_data);
      end
    end
    drain();
  endtask

  task automatic test_credit_exhaust();
    int accepts;
    do_reset();
    d2 = {$urandom, $urandom, $urandom, $urandom};
    v2 = 1'b1;
    accepts = 0;
    for (int i = 0; i < 30; i++) begin
      if (v2 && r2 === 1'b1) accepts++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (accepts != 2 || r2 !== 1'b0 || c2 !== 2'd0) begin
      errors++;
      $display("FAIL exhaust got accepts=%0d ready=%b credits=%0d want 2 0 0", accepts, r2, c2);
    end
    cr2 = 1'b1;
    @(posedge clk);
    #1;
    cr2 = 1'b0;
    checks++;
    if (c2 !== 2'd1 || r2 !== 1'b1) begin
      errors++;
      $display("FAIL exhaust_return got credits=%0d ready=%b want 1 1", c2, r2);
    end
    @(posedge clk);
    #1;
    v2 = 1'b0;
    checks++;
    if (c2 !== 2'd0 || fv2 !== 1'b1) begin
      errors++;
      $display("FAIL exhaust_third got credits=%0d valid=%b want 0 1", c2, fv2);
    end
  endtask

  task automatic test_credit_edge();
    bit a;
    do_reset();
    payload_data = {$urandom, $urandom, $urandom, $urandom};
    payload_valid = 1'b1;
    credit_return = 1'b1;
    flit_ready = 1'b1;
    cycle(a);
    payload_valid = 1'b0;
    credit_return = 1'b0;
    checks++;
    if (!a || credits !== 4'd8 || credit_err !== 1'b0) begin
      errors++;
      $display("FAIL simul_consume_return got acc=%b c=%0d e=%b want 1 8 0", a, credits, credit_err);
    end
    drain();
    credit_return = 1'b1;
    cycle(a);
    credit_return = 1'b0;
    repeat (3) cycle(a);
    checks++;
    if (credits !== 4'd8 || credit_err !== 1'b1) begin
      errors++;
      $display("FAIL overflow got c=%0d e=%b want 8 1", credits, credit_err);
    end
    do_reset();
    checks++;
    if (credit_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear got %b want 0", credit_err);
    end
  endtask

  task automatic test_reset_mid_burst();
    bit a;
    logic [PW-1:0] p;
    do_reset();
    payload_data = {$urandom, $urandom, $urandom, $urandom};
    payload_valid = 1'b1;
    flit_ready = 1'b1;
    cycle(a);
    payload_valid = 1'b0;
    cycle(a);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    reset_model();
    checks++;
    if (flit_valid !== 1'b0 || credits !== 4'd8) begin
      errors++;
      $display("FAIL mid_reset got v=%b c=%0d want 0 8", flit_valid, credits);
    end
    clear_log();
    p = {$urandom, $urandom, $urandom, $urandom};
    payload_data = p;
    payload_valid = 1'b1;
    cycle(a);
    drain();
    checks++;
    if (log_d.size() == 0 || log_d[0] !== p[FW-1:0]) begin
      errors++;
      $display("FAIL mid_reset_restart got %h want %h", (log_d.size() > 0) ? log_d[0] : '0, p[FW-1:0]);
    end
  endtask

  task automatic test_random();
    bit a;
    do_reset();
    for (int i = 0; i < 500; i++) begin
      payload_valid = ($urandom_range(0, 3) != 0);
      payload_data = {$urandom, $urandom, $urandom, $urandom};
      flit_ready = ($urandom_range(0, 3) != 0);
      credit_return = ($urandom_range(0, 4) == 0);
      cycle(a);
    end
    drain();
  endtask

  initial begin
    rst = 1'b1;
    payload_valid = 1'b0;
    payload_data = '0;
    flit_ready = 1'b0;
    credit_return = 1'b0;
    v2 = 1'b0;
    d2 = '0;
    cr2 = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_credit_exhaust();
    test_credit_edge();
    test_reset_mid_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
